// File: rtl/gate_follow_checker.sv
// Checks that a single-bit BUF/NOT gate output follows its input after the input settles.
// Keeps saturating pass/mismatch counters, a sticky error flag and first-failure capture.
module gate_follow_checker #(
    parameter bit          INVERT     = 1'b0,
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             gate_a,
    input  logic             gate_y,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             err,
    output logic             first_err_valid,
    output logic             first_err_a,
    output logic             first_err_y,
    output logic             chk_pulse,
    output logic             chk_fail
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, WAIT} state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state, state_nxt;
    logic [3:0] settle_cnt, settle_nxt;
    logic       a_meta, a_s, a_prev, y_meta, y_s;
    logic       a_chg, mismatch, in_check;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta <= 1'b0;
            a_s    <= 1'b0;
            a_prev <= 1'b0;
            y_meta <= 1'b0;
            y_s    <= 1'b0;
        end else begin
            a_meta <= gate_a;
            a_s    <= a_meta;
            a_prev <= a_s;
            y_meta <= gate_y;
            y_s    <= y_meta;
        end
    end

    assign a_chg    = a_s ^ a_prev;
    assign mismatch = y_s != (a_s ^ INVERT);
    assign in_check = (state == CHECK);

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt  = SETTLE;
                    settle_nxt = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (a_chg) begin
                    settle_nxt = SETTLE_LD;
                end else if (settle_cnt == 4'd1) begin
                    state_nxt = CHECK;
                end else begin
                    settle_nxt = settle_cnt - 4'd1;
                end
            end
            CHECK: state_nxt = WAIT;
            WAIT: begin
                // Y-only activity is deliberately ignored here
                if (a_chg) begin
                    state_nxt  = SETTLE;
                    settle_nxt = SETTLE_LD;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!en) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            chk_pulse  <= 1'b0;
            chk_fail   <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            chk_pulse  <= in_check;
            chk_fail   <= in_check && mismatch;
        end
    end

    // clr outranks a coincident check; the strobe above still fires
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            check_cnt       <= '0;
            mismatch_cnt    <= '0;
            err             <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_a     <= 1'b0;
            first_err_y     <= 1'b0;
        end else if (in_check) begin
            if (check_cnt != CNT_MAX) begin
                check_cnt <= check_cnt + 1'b1;
            end
            if (mismatch) begin
                err <= 1'b1;
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_a     <= a_s;
                    first_err_y     <= y_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_follow_checker.sv
// Bench for gate_follow_checker: three parameterisations share one stimulus stream and are
// compared every cycle against a stability-timer reference model, plus directed checks.
module tb_gate_follow_checker;

    logic clk, rst, en, clr, ga, gy;

    logic [7:0] cc0, mc0, cc1, mc1;
    logic [2:0] cc2, mc2;
    logic err0, fev0, fea0, fey0, p0, f0;
    logic err1, fev1, fea1, fey1, p1, f1;
    logic err2, fev2, fea2, fey2, p2, f2;

    gate_follow_checker #(.INVERT(1'b0), .SETTLE_CYC(3), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .gate_a(ga), .gate_y(gy),
        .check_cnt(cc0), .mismatch_cnt(mc0), .err(err0), .first_err_valid(fev0),
        .first_err_a(fea0), .first_err_y(fey0), .chk_pulse(p0), .chk_fail(f0));

    gate_follow_checker #(.INVERT(1'b1), .SETTLE_CYC(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .gate_a(ga), .gate_y(gy),
        .check_cnt(cc1), .mismatch_cnt(mc1), .err(err1), .first_err_valid(fev1),
        .first_err_a(fea1), .first_err_y(fey1), .chk_pulse(p1), .chk_fail(f1));

    gate_follow_checker #(.INVERT(1'b0), .SETTLE_CYC(15), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .gate_a(ga), .gate_y(gy),
        .check_cnt(cc2), .mismatch_cnt(mc2), .err(err2), .first_err_valid(fev2),
        .first_err_a(fea2), .first_err_y(fey2), .chk_pulse(p2), .chk_fail(f2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    localparam bit          P_INV[3] = '{1'b0, 1'b1, 1'b0};
    localparam int unsigned P_SC[3]  = '{3, 1, 15};
    localparam int unsigned P_MAX[3] = '{255, 255, 7};

    // reference state: synchroniser history, stability timer and statistics
    bit          m_am[3], m_as[3], m_ap[3], m_ym[3], m_ys[3];
    bit          m_run[3], m_timing[3], m_due[3];
    int unsigned m_quiet[3];
    int unsigned m_cc[3], m_mc[3];
    bit          m_err[3], m_fev[3], m_fea[3], m_fey[3], m_pulse[3], m_fail[3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int i);
        bit chg, bad;
        if (rst) begin
            m_am[i] = 0; m_as[i] = 0; m_ap[i] = 0; m_ym[i] = 0; m_ys[i] = 0;
            m_run[i] = 0; m_timing[i] = 0; m_due[i] = 0; m_quiet[i] = 0;
            m_cc[i] = 0; m_mc[i] = 0; m_err[i] = 0; m_fev[i] = 0;
            m_fea[i] = 0; m_fey[i] = 0; m_pulse[i] = 0; m_fail[i] = 0;
            return;
        end
        chg = (m_as[i] != m_ap[i]);
        bad = (m_ys[i] != (m_as[i] ^ P_INV[i]));
        m_pulse[i] = m_due[i];
        m_fail[i]  = m_due[i] && bad;
        if (clr) begin
            m_cc[i] = 0; m_mc[i] = 0; m_err[i] = 0;
            m_fev[i] = 0; m_fea[i] = 0; m_fey[i] = 0;
        end else if (m_due[i]) begin
            if (m_cc[i] < P_MAX[i]) m_cc[i]++;
            if (bad) begin
                if (m_mc[i] < P_MAX[i]) m_mc[i]++;
                m_err[i] = 1;
                if (!m_fev[i]) begin
                    m_fev[i] = 1; m_fea[i] = m_as[i]; m_fey[i] = m_ys[i];
                end
            end
        end
        if (!en) begin
            m_run[i] = 0; m_timing[i] = 0; m_due[i] = 0;
        end else if (!m_run[i]) begin
            m_run[i] = 1; m_timing[i] = 1; m_quiet[i] = 0;
        end else if (m_due[i]) begin
            m_due[i] = 0;
        end else if (m_timing[i]) begin
            if (chg) m_quiet[i] = 0;
            else if (m_quiet[i] + 1 == P_SC[i]) begin
                m_timing[i] = 0; m_due[i] = 1;
            end else m_quiet[i]++;
        end else if (chg) begin
            m_timing[i] = 1; m_quiet[i] = 0;
        end
        m_ap[i] = m_as[i]; m_as[i] = m_am[i]; m_am[i] = ga;
        m_ys[i] = m_ym[i]; m_ym[i] = gy;
    endtask

    function automatic logic [31:0] model_pack(input int i);
        return {8'(m_cc[i]), 8'(m_mc[i]), 10'd0, m_err[i], m_fev[i], m_fea[i], m_fey[i],
                m_pulse[i], m_fail[i]};
    endfunction

    logic [31:0] got0, got1, got2;
    assign got0 = {cc0, mc0, 10'd0, err0, fev0, fea0, fey0, p0, f0};
    assign got1 = {cc1, mc1, 10'd0, err1, fev1, fea1, fey1, p1, f1};
    assign got2 = {5'd0, cc2, 5'd0, mc2, 10'd0, err2, fev2, fea2, fey2, p2, f2};

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        cyc++;
        @(negedge clk);
        check_val("u0_model", got0, model_pack(0));
        check_val("u1_model", got1, model_pack(1));
        check_val("u2_model", got2, model_pack(2));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int since, lat, npulse, rate;
        bit fault;

        rst = 1; en = 0; clr = 0; ga = 0; gy = 0;
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_timing[i] = 0; m_due[i] = 0; m_quiet[i] = 0;
        end
        ticks(3);
        check_val("rst_u0", got0, 32'd0);
        check_val("rst_u1", got1, 32'd0);
        check_val("rst_u2", got2, 32'd0);

        // healthy buffer: first check after enable, then 10 follow toggles
        rst = 0; en = 1; ga = 1; gy = 1;
        ticks(24);
        for (int t = 0; t < 10; t++) begin
            ga = ~ga; gy = ga;
            ticks(24);
        end
        check_val("buf_cnt", {cc0, mc0, 7'd0, err0}, {8'd11, 8'd0, 8'd0});
        check_val("inv_all_fail", {cc1, mc1, 5'd0, err1, fev1, fea1}, {8'd11, 8'd11, 8'd7});
        check_val("sat3_pass", {5'd0, cc2, 5'd0, mc2}, {8'd7, 8'd0});

        // stuck-at-1 output; restart the checker so the enable check counts too
        en = 0; clr = 1; tick();
        clr = 0; ticks(2);
        ga = 1; gy = 1; en = 1;
        ticks(24);
        for (int t = 0; t < 4; t++) begin
            ga = ~ga;
            ticks(24);
        end
        check_val("stuck_buf", {cc0, mc0, 4'd0, err0, fev0, fea0, fey0},
                  {8'd5, 8'd2, 8'b0000_1101});
        check_val("stuck_inv", {cc1, mc1, 4'd0, err1, fev1, fea1, fey1},
                  {8'd5, 8'd3, 8'b0000_1111});

        // rapid toggling holds off checks; one pulse 6 edges after the last change
        gy = ga; ticks(24);
        npulse = 0; lat = -1; since = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 20 && i % 2 == 0) begin
                ga = ~ga; gy = ga; since = -1;
            end
            tick();
            since++;
            if (p0) begin
                npulse++; lat = since;
            end
        end
        check_val("burst_pulses", npulse, 1);
        check_val("burst_latency", lat, 6);

        // enable dropped mid-settle: no check fires
        ga = ~ga; gy = ga;
        ticks(3);
        en = 0; npulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (p0) npulse++;
        end
        check_val("en_abort", npulse, 0);
        check_val("err_before_rst", err0, 1'b1);
        rst = 1; tick();
        check_val("rst_err_u0", got0, 32'd0);
        check_val("rst_err_u1", got1, 32'd0);
        rst = 0;

        // clear coincident with a failing check
        ga = 1; gy = 1; en = 1;
        ticks(24);
        check_val("pre_clr_cnt", cc0, 8'd1);
        ga = 0;
        ticks(6);
        clr = 1; tick();
        clr = 0;
        check_val("clr_at_check", {cc0, mc0, 4'd0, err0, fev0, p0, f0}, {8'd0, 8'd0, 8'b0000_0011});
        tick();
        check_val("pulse_one_cyc", p0, 1'b0);

        // randomized traffic against the model
        fault = 0; rate = 4;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) rate = $urandom_range(1, 30);
            if ($urandom_range(0, rate) == 0) ga = ~ga;
            if ($urandom_range(0, 59) == 0) fault = ~fault;
            gy = ga ^ fault;
            if ($urandom_range(0, 29) == 0) gy = ~gy;
            en  = ($urandom_range(0, 59) != 0);
            clr = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_follow_checker.md
Name: gate_follow_checker

Overview:
- Sequential checker that sits on the far side of a single-bit gate (BUF or NOT) and verifies that the gate output follows its input.
- Observes the gate's input and output and synchronises both into the clk domain.
- After each settled input change, checks the output once against the expected function.
- Keeps saturating pass/mismatch counters, a sticky error flag and a first-failure capture, for on-chip self-test of the gate library.

Parameters:
INVERT, 0, expected function: 0 = buffer (Y==A), 1 = inverter (Y==~A)
SETTLE_CYC, 3, cycles a synchronised input must stay stable before the output is checked; legal range 1..15
CNT_W, 8, width of check and mismatch counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  checker enable; 0 parks the FSM in IDLE
clr  input  1  synchronous clear of counters, sticky flag and capture
gate_a  input  1  asynchronous copy of the gate input
gate_y  input  1  asynchronous copy of the gate output
check_cnt  output  CNT_W  number of checks performed, saturating
mismatch_cnt  output  CNT_W  number of failed checks, saturating
err  output  1  sticky: set on first mismatch
first_err_valid  output  1  first_err_a/first_err_y hold a captured failure
first_err_a  output  1  synchronised A value at the first failure
first_err_y  output  1  synchronised Y value at the first failure
chk_pulse  output  1  one-cycle strobe when a check is performed
chk_fail  output  1  valid with chk_pulse; 1 = mismatch

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FSM=IDLE, settle counter 0, synchronisers 0. rst has priority over clr and en.
- Synchronisers:
  - gate_a and gate_y each pass through a 2-flop synchroniser, giving a_s and y_s.
  - a_prev registers a_s.
  - "A change" means a_s != a_prev.
- Expected output: exp = a_s XOR INVERT.
- FSM states: IDLE, SETTLE, CHECK, WAIT.
  - IDLE: when en=1, load settle counter with SETTLE_CYC and go to SETTLE. The first check after enable happens without requiring an A change.
  - SETTLE: decrement the counter each cycle. An A change reloads it to SETTLE_CYC and stays in SETTLE. Go to CHECK when counter==1 and no A change.
  - CHECK (exactly one cycle):
    - Assert chk_pulse=1 and chk_fail=(y_s != exp).
    - Increment check_cnt.
    - On fail: increment mismatch_cnt, set err. If first_err_valid=0, capture a_s/y_s and set first_err_valid.
    - Next state is WAIT.
  - WAIT: an A change reloads the settle counter and goes to SETTLE. Y changes alone are ignored.
- en=0 in any non-IDLE state: go to IDLE at the next edge; an in-progress settle is abandoned. Counters, err and capture are retained.
- Latency: gate_a toggles, then 2 cycles of synchronisation, then A-change detected, then SETTLE_CYC cycles, then chk_pulse. chk_pulse is asserted SETTLE_CYC+3 edges after the first edge at which gate_a is sampled changed.
- Counters saturate at 2^CNT_W-1 and never wrap. err stays set while mismatch_cnt is saturated.
- clr=1:
  - Clears check_cnt, mismatch_cnt, err, first_err_valid, first_err_a and first_err_y.
  - FSM state and synchronisers are unaffected.
  - If clr coincides with CHECK, clr wins: counters read 0 afterwards. chk_pulse/chk_fail still assert for that cycle.
- chk_pulse and chk_fail are registered outputs, 0 in all states other than the cycle following CHECK entry.
- Glitch on gate_a shorter than one clock may be missed by the synchroniser; no check is required for it.

Test Plan:
- INVERT=0, SETTLE_CYC=3: rst, en=1, drive gate_a=gate_y=1, then toggle both to 0, repeated 10 times -> 11 chk_pulse with chk_fail=0, check_cnt=11, mismatch_cnt=0, err=0.
- INVERT=0: gate_a toggles while gate_y is held at 1 (faulty buffer), 4 toggles starting from a=1 -> fails on a=0 checks. first_err_a=0, first_err_y=1, err=1, mismatch_cnt=2, check_cnt=5.
- INVERT=1: gate_y=~gate_a, 5 toggles -> mismatch_cnt=0. Then force gate_y=gate_a and toggle once -> chk_fail=1, mismatch_cnt=1.
- SETTLE_CYC=3: gate_a toggles every 2 cycles for 20 cycles, then holds -> no chk_pulse during toggling. Exactly one chk_pulse 6 edges after the last sampled change.
- CNT_W=3, persistent fault, 10 checks -> mismatch_cnt and check_cnt stick at 7, err=1. Assert clr coincident with a CHECK -> both counters 0 next cycle, err=0.
- Mid-operation: deassert en during SETTLE -> FSM to IDLE, no chk_pulse. Assert rst while err=1 -> all outputs 0 on the next edge.
